// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared bus types and FSM encodings for the burst RAM controller.
package ram_ctrl_pkg;
   localparam int DW = 64;
   localparam int SW = DW / 8;
   typedef logic [2:0] state_t;
   localparam state_t IDLE       = 3'd0;
   localparam state_t WRITE      = 3'd1;
   localparam state_t READ_ISSUE = 3'd2;
   localparam state_t READ_WAIT  = 3'd3;
   localparam state_t DONE       = 3'd4;
   typedef struct packed {
      logic          valid;
      logic          is_write;
      logic [63:0]   addr;
      logic [3:0]    len;
      logic [SW-1:0] strobe;
      logic [DW-1:0] data;
   } req_t;
   typedef struct packed {
      logic          ready;
      logic          last;
      logic [DW-1:0] data;
   } resp_t;
endpackage

// File: rtl/ram_ctrl_if.sv
// ram_ctrl_if: request/response bus plus single-port RAM side of the controller.
interface ram_ctrl_if import ram_ctrl_pkg::*; #(parameter int ADDR_WIDTH = 10);
   logic                  req_valid;
   logic                  req_is_write;
   logic [63:0]           req_addr;
   logic [3:0]            req_len;
   logic [SW-1:0]         req_strobe;
   logic [DW-1:0]         req_data;
   logic                  resp_ready;
   logic                  resp_last;
   logic [DW-1:0]         resp_data;
   logic                  ram_en;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [SW-1:0]         ram_strobe;
   logic [DW-1:0]         ram_wdata;
   logic [DW-1:0]         ram_rdata;
   modport master (
      output req_valid, req_is_write, req_addr, req_len, req_strobe, req_data, ram_rdata,
      input  resp_ready, resp_last, resp_data, ram_en, ram_addr, ram_strobe, ram_wdata
   );
   modport slave (
      input  req_valid, req_is_write, req_addr, req_len, req_strobe, req_data, ram_rdata,
      output resp_ready, resp_last, resp_data, ram_en, ram_addr, ram_strobe, ram_wdata
   );
endinterface

// File: rtl/ram_ctrl_latency_counter.sv
// latency_counter: counts down DEPTH cycles after load; done_o marks the final one.
module latency_counter #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst_i,
   input  logic load_i,
   output logic done_o
);
   localparam int W = DEPTH > 2 ? $clog2(DEPTH) : 1;
   localparam logic [W-1:0] LOAD = W'(DEPTH > 0 ? DEPTH - 1 : 0);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load_i ? LOAD : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
   always_ff @(posedge clk) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
   assign done_o = cnt_q == '0;
endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: burst controller turning bus requests into single-port RAM accesses.
// Outputs decode from state so that reset silences them on the very next cycle.
module ram_ctrl import ram_ctrl_pkg::*; #(
   parameter int ADDR_WIDTH   = 10,
   parameter int DATA_WIDTH   = 64,
   parameter int READ_LATENCY = 1
) (
   input  logic     clk,
   input  logic     reset,
   ram_ctrl_if.slave bus
);
   req_t                  req;
   resp_t                 resp;
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d, beat_addr;
   logic [3:0]            len_q, len_d, beat_q, beat_d;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  lat_done, deliver, last, active, unused_addr;
   assign req = '{valid: bus.req_valid, is_write: bus.req_is_write, addr: bus.req_addr,
                  len: bus.req_len, strobe: bus.req_strobe, data: bus.req_data};
   assign rdata       = bus.ram_rdata;
   assign unused_addr = ^{req.addr[63:ADDR_WIDTH+3], req.addr[2:0]};
   assign beat_addr   = base_q + ADDR_WIDTH'(beat_q);
   assign deliver     = state_q == WRITE || (state_q == READ_ISSUE && READ_LATENCY == 0) ||
                        (state_q == READ_WAIT && lat_done);
   assign last        = deliver && beat_q == len_q;
   assign active      = state_q == WRITE || state_q == READ_ISSUE || state_q == READ_WAIT;
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      len_d   = len_q;
      beat_d  = (deliver && !last) ? beat_q + 4'd1 : beat_q;
      case (state_q)
         IDLE: if (req.valid) begin
            state_d = req.is_write ? WRITE : READ_ISSUE;
            base_d  = req.addr[ADDR_WIDTH+2:3];
            len_d   = req.len;
            beat_d  = '0;
         end
         WRITE:      state_d = last ? DONE : WRITE;
         READ_ISSUE: state_d = READ_LATENCY == 0 ? (last ? DONE : READ_ISSUE) : READ_WAIT;
         READ_WAIT:  state_d = lat_done ? (last ? DONE : READ_ISSUE) : READ_WAIT;
         default:    state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         base_q  <= '0;
         len_q   <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
      end
   end
   latency_counter #(.DEPTH(READ_LATENCY)) u_lat (
      .clk    (clk),
      .rst_i  (reset),
      .load_i (state_q == READ_ISSUE),
      .done_o (lat_done)
   );
   assign resp = '{ready: deliver, last: last,
                   data: (deliver && state_q != WRITE) ? rdata : '0};
   assign bus.resp_ready = resp.ready;
   assign bus.resp_last  = resp.last;
   assign bus.resp_data  = resp.data;
   assign bus.ram_en     = state_q == WRITE || state_q == READ_ISSUE;
   assign bus.ram_addr   = active ? beat_addr : '0;
   assign bus.ram_strobe = state_q == WRITE ? req.strobe : '0;
   assign bus.ram_wdata  = state_q == WRITE ? req.data : '0;
endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: scoreboard bench driving a READ_LATENCY=1 and a READ_LATENCY=0 controller.
module tb_ram_ctrl;
   typedef struct {
      bit          wr;
      logic [9:0]  addr;
      logic [7:0]  strb;
      logic [63:0] data;
      bit          last;
      int          gap;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rv = 1'b0, rw = 1'b0, sel = 1'b1;
   logic [63:0] raddr = '0, rdat = '0, rd1;
   logic [3:0]  rlen = '0;
   logic [7:0]  rstrb = '0;
   logic [63:0] mem1 [1024], mem0 [1024], sh1 [1024], sh0 [1024];
   exp_t        q[$];
   int          n_chk = 0, n_fail = 0, cyc = 0, last_cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   ram_ctrl_if #(.ADDR_WIDTH(10)) if1 ();
   ram_ctrl_if #(.ADDR_WIDTH(10)) if0 ();
   assign if1.req_valid = rv & sel;
   assign if0.req_valid = rv & ~sel;
   assign if1.req_is_write = rw;
   assign if0.req_is_write = rw;
   assign if1.req_addr = raddr;
   assign if0.req_addr = raddr;
   assign if1.req_len = rlen;
   assign if0.req_len = rlen;
   assign if1.req_strobe = rstrb;
   assign if0.req_strobe = rstrb;
   assign if1.req_data = rdat;
   assign if0.req_data = rdat;
   assign if1.ram_rdata = rd1;
   assign if0.ram_rdata = mem0[if0.ram_addr];
   ram_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .READ_LATENCY(1)) u_dut1 (.clk(clk), .reset(rst), .bus(if1));
   ram_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .READ_LATENCY(0)) u_dut0 (.clk(clk), .reset(rst), .bus(if0));
   // byte-strobed RAMs: one registered read port, one combinational
   always @(posedge clk) begin
      if (if1.ram_en) begin
         rd1 <= mem1[if1.ram_addr];
         for (int b = 0; b < 8; b++) if (if1.ram_strobe[b]) mem1[if1.ram_addr][b*8+:8] = if1.ram_wdata[b*8+:8];
      end
      if (if0.ram_en)
         for (int b = 0; b < 8; b++) if (if0.ram_strobe[b]) mem0[if0.ram_addr][b*8+:8] = if0.ram_wdata[b*8+:8];
   end
   function automatic logic [63:0] init_word(input int i);
      return {32'hC0DE_0000 + 32'(i), 32'h5A5A_0000 ^ 32'(i)};
   endfunction
   function automatic logic [6:0] outs(input bit s);
      return s ? {if1.ram_en, if1.resp_ready, if1.resp_last, |if1.ram_addr, |if1.ram_strobe, |if1.ram_wdata, |if1.resp_data}
               : {if0.ram_en, if0.resp_ready, if0.resp_last, |if0.ram_addr, |if0.ram_strobe, |if0.ram_wdata, |if0.resp_data};
   endfunction
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic mon(input logic last, input logic en, input logic [9:0] addr, input logic [7:0] strb,
                      input logic [63:0] wd, input logic [63:0] rd);
      exp_t e;
      check("beat_expected", 64'(q.size() != 0), 1);
      if (q.size() != 0) begin
         e = q.pop_front();
         check("resp_last", last, e.last);
         if (e.wr) begin
            check("wr_en", en, 1);
            check("wr_addr", addr, e.addr);
            check("wr_strb", strb, e.strb);
            check("wr_data", wd, e.data);
         end else check("rd_data", rd, e.data);
         if (e.gap != 0) check("beat_gap", 64'(cyc - last_cyc), 64'(e.gap));
         last_cyc = cyc;
      end
   endtask
   always @(negedge clk) begin
      if (if1.resp_ready) mon(if1.resp_last, if1.ram_en, if1.ram_addr, if1.ram_strobe, if1.ram_wdata, if1.resp_data);
      if (if0.resp_ready) mon(if0.resp_last, if0.ram_en, if0.ram_addr, if0.ram_strobe, if0.ram_wdata, if0.resp_data);
      if (!if1.resp_ready && if1.resp_data != 0) check("idle_data1", if1.resp_data, 0);
      if (!if0.resp_ready && if0.resp_data != 0) check("idle_data0", if0.resp_data, 0);
   end
   task automatic push_exp(input bit s, input bit wr, input logic [63:0] a, input logic [3:0] len,
                           input logic [7:0] st, input logic [63:0] d0, input int nb);
      exp_t       e;
      logic [9:0] w;
      for (int k = 0; k < nb; k++) begin
         w      = a[12:3] + 10'(k);
         e.wr   = wr;
         e.addr = w;
         e.strb = st;
         e.last = k == int'(len);
         e.gap  = k == 0 ? 0 : (wr || !s) ? 1 : 2;
         if (wr) begin
            e.data = d0 + 64'(k);
            for (int b = 0; b < 8; b++) if (st[b]) begin
               if (s) sh1[w][b*8+:8] = e.data[b*8+:8];
               else   sh0[w][b*8+:8] = e.data[b*8+:8];
            end
         end else e.data = s ? sh1[w] : sh0[w];
         q.push_back(e);
      end
   endtask
   task automatic xfer(input bit s, input bit wr, input logic [63:0] a, input logic [3:0] len,
                       input logic [7:0] st, input logic [63:0] d0);
      int n;
      push_exp(s, wr, a, len, st, d0, int'(len) + 1);
      sel = s; rw = wr; raddr = a; rlen = len; rstrb = st; rdat = d0; rv = 1'b1;
      @(posedge clk); #1;
      rv = 1'b0; rw = ~wr; raddr = ~a; rlen = ~len;
      if (wr) for (int k = 1; k <= int'(len); k++) begin
         @(posedge clk); #1;
         rdat = d0 + 64'(k);
      end
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      check("drain", 64'(q.size()), 0);
      @(posedge clk); #1;
      check("done_quiet", outs(s), 0);
      @(posedge clk); #1;
   endtask
   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem1[i] = init_word(i); mem0[i] = init_word(i);
         sh1[i]  = init_word(i); sh0[i]  = init_word(i);
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_quiet1", outs(1), 0);
      check("rst_quiet0", outs(0), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      xfer(1, 1, 64'h18, 4'd0, 8'h0F, 64'h1122334455667788);
      xfer(1, 0, 64'h18, 4'd0, 8'h00, 64'h0);
      xfer(1, 0, 64'h40, 4'd3, 8'h00, 64'h0);
      xfer(1, 1, 64'h1FF8, 4'd1, 8'hFF, 64'hA0A0_0000_0000_0000);
      xfer(1, 0, 64'h1FF8, 4'd1, 8'h00, 64'h0);
      xfer(1, 1, 64'hA0, 4'd0, 8'hFF, 64'h0);
      xfer(1, 1, 64'hA0, 4'd0, 8'h80, 64'hAB00_0000_0000_0000);
      xfer(1, 0, 64'hA0, 4'd0, 8'h00, 64'h0);
      xfer(1, 0, 64'h1FC0, 4'd15, 8'h00, 64'h0);
      xfer(0, 0, 64'h80, 4'd2, 8'h00, 64'h0);
      xfer(0, 1, 64'h200, 4'd2, 8'h3C, 64'h0F0F_F0F0_1234_5678);
      xfer(0, 0, 64'h200, 4'd2, 8'h00, 64'h0);
      // reset lands during beat 2 of an eight-beat write
      push_exp(1, 1, 64'h100, 4'd7, 8'hFF, 64'h7700, 3);
      sel = 1'b1; rw = 1'b1; raddr = 64'h100; rlen = 4'd7; rstrb = 8'hFF; rdat = 64'h7700; rv = 1'b1;
      @(posedge clk); #1;
      rv = 1'b0;
      @(posedge clk); #1;
      rdat = 64'h7701;
      @(posedge clk); #1;
      rdat = 64'h7702;
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_drain", 64'(q.size()), 0);
      for (int i = 0; i < 4; i++) begin
         check("abort_quiet", outs(1), 0);
         if (i == 1) rst = 1'b0;
         @(posedge clk); #1;
      end
      xfer(1, 0, 64'h118, 4'd0, 8'h00, 64'h0);
      xfer(1, 0, 64'h108, 4'd0, 8'h00, 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, RAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, word width; fixed at 64 in this revision.
REQ-003 SHALL have parameter READ_LATENCY, default 1, RAM read latency in cycles, legal range 0..3.
REQ-004 SHALL have ports: clk in 1, clock; reset in 1, synchronous active-high reset.
REQ-005 SHALL have ports: req_valid in 1; req_is_write in 1; req_addr in 64 (byte address); req_len in 4 (beats-1); req_strobe in 8; req_data in 64.
REQ-006 SHALL have ports: resp_ready out 1 (beat accepted or delivered); resp_last out 1; resp_data out 64.
REQ-007 SHALL have RAM-side ports: ram_en out 1; ram_addr out ADDR_WIDTH; ram_strobe out 8; ram_wdata out 64; ram_rdata in 64. These ports match a single-port byte-strobed RAM with READ_LATENCY read latency.

Function
REQ-008 SHALL implement FSM states IDLE, WRITE, READ_ISSUE, READ_WAIT, DONE.
REQ-009 In IDLE with req_valid=1, SHALL latch the base word address req_addr[ADDR_WIDTH+2:3], latch req_len, clear the beat counter, and go to WRITE if req_is_write, else to READ_ISSUE.
REQ-010 In IDLE, SHALL drive resp_ready=0, ram_en=0 and ram_strobe=0.
REQ-011 Beat address SHALL equal base + beat counter, computed modulo 2^ADDR_WIDTH (wrap, no carry out).
REQ-012 In WRITE, every cycle SHALL drive ram_en=1, ram_strobe=req_strobe, ram_wdata=req_data and ram_addr=beat address; SHALL assert resp_ready=1 in the same cycle and increment the beat counter.
REQ-013 In READ_ISSUE, SHALL drive ram_en=1, ram_strobe=0 and ram_addr=beat address.
REQ-014 With READ_LATENCY=0, READ_ISSUE SHALL also assert resp_ready=1 with resp_data=ram_rdata in that cycle.
REQ-015 With READ_LATENCY>0, READ_ISSUE SHALL go to READ_WAIT. READ_WAIT SHALL hold ram_addr and count READ_LATENCY cycles, then assert resp_ready=1 with resp_data=ram_rdata for exactly one cycle.
REQ-016 After each delivered read beat that is not last, SHALL increment the beat counter and return to READ_ISSUE.
REQ-017 SHALL assert resp_last together with resp_ready on the beat where beat counter == latched len.
REQ-018 After the last beat, SHALL enter DONE for one cycle with all outputs inactive, ignoring req_valid, then return to IDLE.
REQ-019 SHALL ignore req_is_write, req_addr and req_len outside IDLE; changes mid-burst SHALL not alter the transaction.
REQ-020 req_len=0 SHALL produce a single beat with resp_last=1.
REQ-021 Read throughput SHALL be one beat per READ_LATENCY+1 cycles; write throughput SHALL be one beat per cycle.
REQ-022 resp_data SHALL be 0 whenever resp_ready=0.

Reset
REQ-023 reset=1 at a clock edge SHALL force IDLE, clear the beat counter and latched fields, and drive every output to 0 in the following cycle.
REQ-024 reset asserted mid-burst SHALL abort the burst with no further RAM writes and no resp_ready; the next request after reset release SHALL be served normally.

Structure
REQ-025 The FSM state enum and the request/response struct types (req_t: valid, is_write, addr, len, strobe, data; resp_t: ready, last, data) SHALL live in the shared bus package.
REQ-026 The read-latency countdown SHALL be one sub-module, latency_counter (load, done, parameter depth).
REQ-027 SHALL contain no memory array; storage stays in the external RAM.

Verification
REQ-028 Single write: addr=0x18, strobe=0x0F, data=0x1122334455667788, len=0 -> one cycle with ram_en=1, ram_addr=3, ram_strobe=0x0F; resp_ready=resp_last=1 in the same cycle.
REQ-029 Burst read with READ_LATENCY=1, len=3, addr=0x40, RAM words 8..11 preloaded -> four resp_ready pulses spaced 2 cycles apart with data of words 8,9,10,11; resp_last only on the 4th pulse.
REQ-030 Wrap-around: ADDR_WIDTH=10, addr=0x1FF8, len=1 write -> writes land at word 1023 then word 0.
REQ-031 Partial strobe: write strobe=0x80, data=0xAB<<56 onto word holding 0 -> subsequent read returns 0xAB00000000000000.
REQ-032 Reset mid-burst: assert reset during beat 2 of a len=7 write -> no ram_en after reset; outputs 0; a following len=0 read completes correctly.
REQ-033 READ_LATENCY=0, len=2 -> three consecutive resp_ready cycles, correct data on each, then one DONE cycle.
